// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter: shares the VRAM port between display fetches and CPU ops run as
// SETUP/STROBE/HOLD cycles, with a posted-write FIFO and a single pending read.
module cga_vram_arbiter #(
   parameter int AW         = 14,
   parameter int DW         = 8,
   parameter int WBUF_DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          isa_op_enable_i,
   input  logic          vram_read_i,
   input  logic [AW-1:0] disp_addr_i,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic          cpu_ack_o,
   output logic [DW-1:0] cpu_rdata_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [DW-1:0] ram_wdata_o,
   output logic          ram_we_o,
   output logic          ram_oe_o,
   input  logic [DW-1:0] ram_rdata_i,
   output logic          wbuf_empty_o,
   output logic          collision_o
);
   localparam int PW = WBUF_DEPTH > 1 ? $clog2(WBUF_DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
   state_t        state_q;
   logic [AW-1:0] fa_q [WBUF_DEPTH];
   logic [DW-1:0] fd_q [WBUF_DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          rd_pend_q, op_we_q, ack_q, coll_q;
   logic [AW-1:0] rd_addr_q, op_addr_q;
   logic [DW-1:0] op_data_q, rdata_q;
   logic          full, push, rd_acc, start, pop;
   // a request is ignored during its own ack cycle so a held req is not taken twice
   assign full   = cnt_q == (PW+1)'(WBUF_DEPTH);
   assign push   = cpu_req_i & cpu_we_i & !full & !ack_q;
   assign rd_acc = cpu_req_i & !cpu_we_i & !rd_pend_q & !ack_q;
   assign start  = state_q == IDLE & isa_op_enable_i & (cnt_q != '0 | rd_pend_q);
   assign pop    = start & cnt_q != '0;
   assign wp_d   = push ? (wp_q == PW'(WBUF_DEPTH-1) ? '0 : wp_q + 1'b1) : wp_q;
   assign rp_d   = pop ? (rp_q == PW'(WBUF_DEPTH-1) ? '0 : rp_q + 1'b1) : rp_q;
   assign cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
   always_ff @(posedge clk_i)
      if (push) begin
         fa_q[wp_q] <= cpu_addr_i;
         fd_q[wp_q] <= cpu_wdata_i;
      end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state_q   <= IDLE;
         wp_q      <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         rd_addr_q <= '0;
         op_we_q   <= 1'b0;
         op_addr_q <= '0;
         op_data_q <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         coll_q    <= 1'b0;
      end else begin
         ack_q  <= push | (state_q == STROBE & !op_we_q);
         coll_q <= coll_q | (state_q != IDLE & vram_read_i);
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         if (rd_acc) begin
            rd_pend_q <= 1'b1;
            rd_addr_q <= cpu_addr_i;
         end
         case (state_q)
            IDLE: if (start) begin
               state_q   <= SETUP;
               op_we_q   <= pop;
               op_addr_q <= pop ? fa_q[rp_q] : rd_addr_q;
               op_data_q <= fd_q[rp_q];
            end
            SETUP: state_q <= STROBE;
            STROBE: begin
               state_q <= HOLD;
               if (!op_we_q) rdata_q <= ram_rdata_i;
            end
            default: begin
               state_q <= IDLE;
               if (!op_we_q) rd_pend_q <= 1'b0;
            end
         endcase
      end
   assign ram_addr_o   = state_q == IDLE ? disp_addr_i : op_addr_q;
   assign ram_oe_o     = state_q == IDLE ? vram_read_i : (state_q == STROBE & !op_we_q);
   assign ram_we_o     = state_q == STROBE & op_we_q;
   assign ram_wdata_o  = op_data_q;
   assign cpu_ack_o    = ack_q;
   assign cpu_rdata_o  = rdata_q;
   assign wbuf_empty_o = cnt_q == '0;
   assign collision_o  = coll_q;
endmodule
